fx2_slavefifo_emu: RTL

Synthesizable model of the FX2 synchronous slave-FIFO endpoint side. It lets FPGA-side FX2 masters be exercised in on-chip loopback and simulation without the USB chip. It presents FX2-native active-low pins (flags, SLRD/SLWR, SLOE, PKTEND, FIFOADR, FD) to the master. Two internal FIFOs are bridged to a host-side stream port: OUT endpoint FIFO2 (host->master) and IN endpoint FIFO4 (master->host, packetised).

---
 rtl/fx2_emu_pkg.sv | 12 +
 rtl/fx2_emu_fifo.sv | 64 ++++++
 rtl/fx2_slavefifo_emu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fx2_emu_pkg.sv
// Shared constants for the FX2 slave-FIFO emulator: endpoint addresses and flag reset value.
package fx2_emu_pkg;

    localparam logic [1:0] FX2_ADR_FIFO2 = 2'd0;
    localparam logic [1:0] FX2_ADR_FIFO3 = 2'd1;
    localparam logic [1:0] FX2_ADR_FIFO4 = 2'd2;
    localparam logic [1:0] FX2_ADR_FIFO5 = 2'd3;

    // Bits are {~FIFO4_full, ~FIFO3_empty, ~FIFO2_empty}; after reset only "FIFO4 not full" is high.
    localparam logic [2:0] FX2_FLAGS_RST = 3'b100;

endpackage

// File: rtl/fx2_emu_fifo.sv
// First-word fall-through FIFO with a separate commit pointer; readers only see committed entries.
// patch_i sets the MSB of the most recently written entry (used as the packet "last" bit).
module fx2_emu_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  commit_i,
    input  logic                  patch_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  avail_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   pending_o
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
    logic [DEPTH_LOG2-1:0] last_idx;
    logic                  push, pop;

    always_comb begin
        full_o       = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
        avail_o      = rd_ptr_q != commit_ptr_q;
        push         = wr_en_i & ~full_o;
        pop          = rd_en_i & avail_o;
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        // Committing publishes everything written up to and including this edge's write.
        commit_ptr_d = commit_i ? wr_ptr_d : commit_ptr_q;
        pending_o    = wr_ptr_q - commit_ptr_q;
        last_idx     = wr_ptr_q[DEPTH_LOG2-1:0] - 1'b1;
        rd_data_o    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            commit_ptr_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            commit_ptr_q <= commit_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
        end else if (patch_i) begin
            mem_q[last_idx][WIDTH-1] <= 1'b1;
        end
    end

endmodule

// File: rtl/fx2_slavefifo_emu.sv
// FX2 synchronous slave-FIFO endpoint emulator: FIFO2 (host->master) and packetised FIFO4 (master->host).
// Define FX2_FLAG_DELAY_EN to register FX2_flags/FX2_PA_7 once more, mimicking real FX2 flag latency.
module fx2_slavefifo_emu
    import fx2_emu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int PKT_SIZE   = 512
) (
    input  logic       FX2_CLK,
    input  logic       FX2_RST,
    input  logic       FX2_SLRD,
    input  logic       FX2_SLWR,
    input  logic       FX2_SLOE,
    input  logic       FX2_PKTEND,
    input  logic [1:0] FX2_FIFOADR,
    input  logic [7:0] FX2_FD_in,
    output logic [7:0] FX2_FD_out,
    output logic       FX2_FD_oe,
    output logic [2:0] FX2_flags,
    output logic       FX2_PA_7,
    input  logic [7:0] h_wr_data,
    input  logic       h_wr_en,
    output logic       h_wr_full,
    output logic [7:0] h_rd_data,
    output logic       h_rd_last,
    output logic       h_rd_valid,
    input  logic       h_rd_en,
    output logic       err_ovf,
    output logic       err_unf
);

    localparam int PW = DEPTH_LOG2 + 1;

    logic          rd_fire, wr_fire, pkt_fire;
    logic          f4_push, f4_last, f4_patch, f4_commit;
    logic          f2_avail, f2_full, f4_avail, f4_full;
    logic [7:0]    f2_head;
    logic [8:0]    f4_head;
    logic [PW-1:0] f4_pending, f2_pending_unused;
    logic          err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
    logic [2:0]    flags_d;
    logic          pa7_d;

    always_comb begin
        rd_fire   = ~FX2_SLRD & (FX2_FIFOADR == FX2_ADR_FIFO2);
        wr_fire   = ~FX2_SLWR & (FX2_FIFOADR == FX2_ADR_FIFO4);
        pkt_fire  = ~FX2_PKTEND & (FX2_FIFOADR == FX2_ADR_FIFO4);
        f4_push   = wr_fire & ~f4_full;
        f4_last   = f4_push & ((f4_pending + 1'b1 == PW'(PKT_SIZE)) | pkt_fire);
        // A bare PKTEND closes the open packet by marking its already-stored final byte.
        f4_patch  = pkt_fire & ~f4_push & (f4_pending != '0);
        f4_commit = f4_last | f4_patch;
        err_ovf_d = err_ovf_q | (wr_fire & f4_full);
        err_unf_d = err_unf_q | (rd_fire & ~f2_avail);
        flags_d   = {~f4_full, 1'b0, f2_avail};
        pa7_d     = 1'b0;
    end

    always_ff @(posedge FX2_CLK) begin
        if (FX2_RST) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    fx2_emu_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo2 (
        .clk_i     (FX2_CLK),
        .rst_i     (FX2_RST),
        .wr_en_i   (h_wr_en),
        .wr_data_i (h_wr_data),
        .commit_i  (1'b1),
        .patch_i   (1'b0),
        .rd_en_i   (rd_fire),
        .rd_data_o (f2_head),
        .avail_o   (f2_avail),
        .full_o    (f2_full),
        .pending_o (f2_pending_unused)
    );

    fx2_emu_fifo #(.WIDTH(9), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo4 (
        .clk_i     (FX2_CLK),
        .rst_i     (FX2_RST),
        .wr_en_i   (wr_fire),
        .wr_data_i ({f4_last, FX2_FD_in}),
        .commit_i  (f4_commit),
        .patch_i   (f4_patch),
        .rd_en_i   (h_rd_en),
        .rd_data_o (f4_head),
        .avail_o   (f4_avail),
        .full_o    (f4_full),
        .pending_o (f4_pending)
    );

    assign FX2_FD_oe  = ~FX2_SLOE & (FX2_FIFOADR == FX2_ADR_FIFO2);
    assign FX2_FD_out = f2_avail ? f2_head : 8'h00;
    assign h_wr_full  = f2_full;
    assign h_rd_valid = f4_avail;
    assign h_rd_data  = f4_avail ? f4_head[7:0] : 8'h00;
    assign h_rd_last  = f4_avail & f4_head[8];
    assign err_ovf    = err_ovf_q;
    assign err_unf    = err_unf_q;

`ifdef FX2_FLAG_DELAY_EN
    logic [2:0] flags_q;
    logic       pa7_q;

    always_ff @(posedge FX2_CLK) begin
        if (FX2_RST) begin
            flags_q <= FX2_FLAGS_RST;
            pa7_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            pa7_q   <= pa7_d;
        end
    end

    assign FX2_flags = flags_q;
    assign FX2_PA_7  = pa7_q;
`else
    assign FX2_flags = flags_d;
    assign FX2_PA_7  = pa7_d;
`endif

endmodule
